// File: rtl/mul_share_sched.sv
// rtl/mul_share_sched.sv - four signed products a*b, c*d, e*f, g*h through one shared pipelined multiplier
module mul_share_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int MUL_LAT    = 2
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Start,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [DATA_WIDTH-1:0] c,
    input  logic signed [DATA_WIDTH-1:0] d,
    input  logic signed [DATA_WIDTH-1:0] e,
    input  logic signed [DATA_WIDTH-1:0] f,
    input  logic signed [DATA_WIDTH-1:0] g,
    input  logic signed [DATA_WIDTH-1:0] h,
    output logic                         Done,
    output logic                         Busy,
    output logic signed [DATA_WIDTH-1:0] i,
    output logic signed [DATA_WIDTH-1:0] j,
    output logic signed [DATA_WIDTH-1:0] k,
    output logic signed [DATA_WIDTH-1:0] l
);

    localparam int W2 = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {ST_WAIT, ST_ISSUE, ST_DRAIN, ST_FINAL} state_t;

    state_t                         state, state_nxt;
    logic signed [DATA_WIDTH-1:0]   opnd [8];
    logic [1:0]                     idx;
    logic [MUL_LAT-1:0]             pv;
    logic [1:0]                     ptag  [MUL_LAT];
    logic signed [DATA_WIDTH-1:0]   pprod [MUL_LAT];
    logic signed [DATA_WIDTH-1:0]   mul_x, mul_y;
    logic signed [W2-1:0]           mul_full;
    logic                           wr_en;
    logic [1:0]                     wr_tag;

    // Only the low half of the full product is kept; wrap is intentional.
    always_comb begin
        mul_x    = opnd[{idx, 1'b0}];
        mul_y    = opnd[{idx, 1'b1}];
        mul_full = W2'(mul_x) * W2'(mul_y);
        wr_en    = pv[MUL_LAT-1];
        wr_tag   = ptag[MUL_LAT-1];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT:  if (Start) state_nxt = ST_ISSUE;
            ST_ISSUE: if (idx == 2'd3) state_nxt = ST_DRAIN;
            ST_DRAIN: if (wr_en && wr_tag == 2'd3) state_nxt = ST_FINAL;
            ST_FINAL: state_nxt = ST_WAIT;
            default:  state_nxt = ST_WAIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) state <= ST_WAIT;
        else     state <= state_nxt;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Done <= 1'b0;
            Busy <= 1'b0;
            idx  <= 2'd0;
            i    <= '0;
            j    <= '0;
            k    <= '0;
            l    <= '0;
            pv   <= '0;
            for (int s = 0; s < 8; s++) opnd[s] <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                ptag[s]  <= 2'd0;
                pprod[s] <= '0;
            end
        end else begin
            case (state)
                ST_WAIT: begin
                    Done <= 1'b0;
                    if (Start) begin
                        opnd[0] <= a; opnd[1] <= b; opnd[2] <= c; opnd[3] <= d;
                        opnd[4] <= e; opnd[5] <= f; opnd[6] <= g; opnd[7] <= h;
                        Busy <= 1'b1;
                        idx  <= 2'd0;
                    end
                end
                ST_ISSUE: idx <= idx + 2'd1;
                ST_FINAL: begin
                    Done <= 1'b1;
                    Busy <= 1'b0;
                end
                default: ;
            endcase

            pv[0]    <= (state == ST_ISSUE);
            ptag[0]  <= idx;
            pprod[0] <= mul_full[DATA_WIDTH-1:0];
            for (int s = 1; s < MUL_LAT; s++) begin
                pv[s]    <= pv[s-1];
                ptag[s]  <= ptag[s-1];
                pprod[s] <= pprod[s-1];
            end

            if (wr_en) begin
                case (wr_tag)
                    2'd0: i <= pprod[MUL_LAT-1];
                    2'd1: j <= pprod[MUL_LAT-1];
                    2'd2: k <= pprod[MUL_LAT-1];
                    default: l <= pprod[MUL_LAT-1];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_share_sched.sv
// tb/tb_mul_share_sched.sv - random and directed stimulus against an edge-timed reference model, MUL_LAT 1/2/4
module tb_mul_share_sched;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [15:0] ops [8];

    logic               o_done [3];
    logic               o_busy [3];
    logic        [15:0] o_res  [3][4];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    bit          act   [3];
    int          e0    [3];
    logic [15:0] mop   [3][8];
    logic [15:0] exp_r [3][4];

    always #5 clk = ~clk;

    function automatic int lat_of(input int dut);
        return (dut == 0) ? 1 : ((dut == 1) ? 2 : 4);
    endfunction

    function automatic logic [15:0] prod(input logic [15:0] x, input logic [15:0] y);
        int p;
        p = int'($signed(x)) * int'($signed(y));
        return p[15:0];
    endfunction

    task automatic check(input string tag, input int dut, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s lat=%0d cyc=%0d got=%0h expected=%0h", tag, lat_of(dut), cyc, got, exp);
        end
    endtask

    for (genvar gd = 0; gd < 3; gd++) begin : g_dut
        mul_share_sched #(
            .DATA_WIDTH(16),
            .MUL_LAT((gd == 0) ? 1 : ((gd == 1) ? 2 : 4))
        ) dut (
            .Clk(clk), .Rst(rst), .Start(start),
            .a(ops[0]), .b(ops[1]), .c(ops[2]), .d(ops[3]),
            .e(ops[4]), .f(ops[5]), .g(ops[6]), .h(ops[7]),
            .Done(o_done[gd]), .Busy(o_busy[gd]),
            .i(o_res[gd][0]), .j(o_res[gd][1]), .k(o_res[gd][2]), .l(o_res[gd][3])
        );
    end

    // Model: a run accepted at edge E0 writes pair n at E(1+n+L), pulses Done after E(5+L)
    // and can only be re-accepted from E(6+L) on. Inputs only change on the falling edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int dd = 0; dd < 3; dd++) begin
            int lat, r;
            lat = lat_of(dd);
            if (rst) begin
                act[dd] = 1'b0;
                for (int n = 0; n < 4; n++) exp_r[dd][n] = 16'h0;
            end else if (start && (!act[dd] || (cyc - e0[dd]) >= 6 + lat)) begin
                act[dd] = 1'b1;
                e0[dd]  = cyc;
                for (int q = 0; q < 8; q++) mop[dd][q] = ops[q];
            end
            r = act[dd] ? (cyc - e0[dd]) : -1;
            for (int n = 0; n < 4; n++)
                if (r == 1 + n + lat) exp_r[dd][n] = prod(mop[dd][2*n], mop[dd][2*n+1]);
            check("done", dd, {15'b0, o_done[dd]}, {15'b0, (r == 5 + lat)});
            check("busy", dd, {15'b0, o_busy[dd]}, {15'b0, (r >= 0 && r < 5 + lat)});
            check("i", dd, o_res[dd][0], exp_r[dd][0]);
            check("j", dd, o_res[dd][1], exp_r[dd][1]);
            check("k", dd, o_res[dd][2], exp_r[dd][2]);
            check("l", dd, o_res[dd][3], exp_r[dd][3]);
        end
    end

    task automatic set_ops(input int v0, input int v1, input int v2, input int v3,
                           input int v4, input int v5, input int v6, input int v7);
        ops[0] = 16'(v0); ops[1] = 16'(v1); ops[2] = 16'(v2); ops[3] = 16'(v3);
        ops[4] = 16'(v4); ops[5] = 16'(v5); ops[6] = 16'(v6); ops[7] = 16'(v7);
    endtask

    task automatic rand_ops();
        for (int q = 0; q < 8; q++) ops[q] = 16'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        set_ops(3, 4, -5, 6, 7, -8, -9, -10);
        pulse_start();
        repeat (12) @(negedge clk);

        set_ops(300, 300, -32768, -1, 32767, 32767, -32768, -32768);
        pulse_start();
        repeat (12) @(negedge clk);

        // Operand change plus a Start during Issue must not disturb the run.
        set_ops(11, -12, 13, 14, -15, 16, 17, 18);
        pulse_start();
        @(negedge clk);
        set_ops(0, 0, 0, 0, 0, 0, 0, 0);
        pulse_start();
        repeat (12) @(negedge clk);

        // Start held high with operands changing every cycle.
        start = 1'b1;
        repeat (40) begin
            rand_ops();
            @(negedge clk);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Reset once i has been written for MUL_LAT=2.
        rand_ops();
        pulse_start();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        set_ops(3, 4, -5, 6, 7, -8, -9, -10);
        pulse_start();
        repeat (12) @(negedge clk);

        repeat (300) begin
            start = ($urandom_range(3) == 0);
            rst   = ($urandom_range(59) == 0);
            if ($urandom_range(2) == 0) rand_ops();
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (15) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
